// File: rtl/rom_arb_pkg.sv
// rom_arb_pkg: shared FSM states, owner encodings and defaults for the ROM access arbiter
package rom_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RETURN} state_t;
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DEBUG = 1'b1;
  localparam int DEF_ROM_LATENCY = 1;
endpackage

// File: rtl/rr_starve_guard.sv
// rr_starve_guard: fetch-priority decision with a streak counter that guarantees debug progress
module rr_starve_guard #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic f_req,
  input  logic d_req,
  input  logic grant,
  input  logic win_debug,
  output logic debug_wins
);
  logic [3:0] streak;
  assign debug_wins = d_req && (!f_req || streak >= 4'(STARVE_LIMIT));
  // count fetch grants made over a pending debug request; any other grant restarts the streak
  always_ff @(posedge clk or posedge rst)
    if (rst) streak <= '0;
    else if (grant) streak <= (win_debug || !d_req) ? '0 : (streak == 4'hf ? streak : streak + 4'd1);
endmodule

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares one synchronous ROM between fetch and debug ports with fixed read latency
module rom_access_arbiter
  import rom_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int ROM_LATENCY  = DEF_ROM_LATENCY,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ack,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_clken,
  input  logic [DATA_W-1:0] rom_q,
  output logic              busy,
  output logic              owner
);
  state_t state;
  logic [1:0] lat_cnt;
  logic grant;
  logic win_d;
  assign grant = !Reset && state == IDLE && Enable && (f_req || d_req);
  assign f_ack = grant && !win_d;
  assign d_ack = grant && win_d;
  assign busy  = state != IDLE;
  rr_starve_guard #(.STARVE_LIMIT(STARVE_LIMIT)) u_guard (
    .clk(Clock),
    .rst(Reset),
    .f_req(f_req),
    .d_req(d_req),
    .grant(grant),
    .win_debug(win_d),
    .debug_wins(win_d)
  );
  // single-outstanding access sequencer: grant, wait out the ROM latency, return the word to its owner
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      state     <= IDLE;
      rom_addr  <= '0;
      rom_clken <= 1'b0;
      lat_cnt   <= '0;
      owner     <= OWN_FETCH;
      f_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      f_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      f_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        IDLE:
          if (grant) begin
            state     <= WAIT;
            rom_addr  <= win_d ? d_addr : f_addr;
            owner     <= win_d ? OWN_DEBUG : OWN_FETCH;
            rom_clken <= 1'b1;
            lat_cnt   <= 2'(ROM_LATENCY);
          end
        WAIT:
          if (lat_cnt == 2'd1) begin
            state     <= RETURN;
            rom_clken <= 1'b0;
            if (owner == OWN_DEBUG) begin
              d_rdata  <= rom_q;
              d_rvalid <= 1'b1;
            end else begin
              f_rdata  <= rom_q;
              f_rvalid <= 1'b1;
            end
          end else lat_cnt <= lat_cnt - 2'd1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Sequences and shares the single synchronous instruction ROM between two requesters: the processor's instruction fetch port and a debug/display read port that dumps ROM words to the hex displays. It owns the ROM `address` and `clken` pins, handles the ROM's fixed read latency, and returns each word to the requester that asked for it. Fetch has priority, and a streak counter guarantees the debug port is never starved. It sits between `ROM` and `Processor` in the top level, replacing the direct switch-driven `clken` wiring.

## Interface

- `ADDR_W`, 32: address width on both requester ports and the ROM.
- `DATA_W`, 32: ROM word width.
- `ROM_LATENCY`, 1: clocks from the first `clken`-high edge with a stable address until `rom_q` is valid. Legal range is 1..3.
- `STARVE_LIMIT`, 4: consecutive fetch grants allowed while debug is pending. Legal range is 1..15.

Ports:

- `Clock`  in  1: single clock for all state.
- `Reset`  in  1: asynchronous, active-high reset.
- `Enable`  in  1: while low, no new grants are issued. An access already in flight completes normally.
- `f_req`  in  1: fetch request. Held high until acked.
- `f_addr`  in  ADDR_W: fetch address. Sampled on the ack cycle.
- `f_ack`  out  1: fetch request accepted.
- `f_rvalid`  out  1: one-cycle pulse marking `f_rdata` as new.
- `f_rdata`  out  DATA_W: fetched word. Holds its value until the next `f_rvalid`.
- `d_req`, `d_addr`, `d_ack`, `d_rvalid`, `d_rdata`: the debug port. Same directions, widths and rules as the fetch port.
- `rom_addr`  out  ADDR_W: ROM address. Registered.
- `rom_clken`  out  1: ROM clock enable. Registered.
- `rom_q`  in  DATA_W: ROM data out.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `owner`  out  1: owner of the current or last access; 0 = fetch, 1 = debug.

## Operation

FSM states are IDLE, WAIT and RETURN.

- **IDLE**
  - If `Enable` is high and any request is high, arbitrate, then:
    - assert the winner's ack combinationally in the same cycle;
    - latch the winner's address into `rom_addr` and set `owner`;
    - set `rom_clken`;
    - load `lat_cnt` with ROM_LATENCY;
    - go to WAIT.
  - Otherwise stay in IDLE with `rom_clken` = 0.
- **WAIT**
  - `rom_clken` = 1 and `rom_addr` is held.
  - `lat_cnt` decrements each cycle.
  - When `lat_cnt` = 1, capture `rom_q` into the owner's rdata register and go to RETURN.
- **RETURN**
  - Pulse the owner's rvalid high for exactly one cycle.
  - `rom_clken` = 0.
  - Go to IDLE.
- **Arbitration**
  - Only one request pending: it wins.
  - Both pending: fetch wins, unless `streak` = STARVE_LIMIT, in which case debug wins.
- **Streak counter** (`streak`, 4 bits, saturating)
  - Increments on a fetch grant made while `d_req` is high.
  - Clears on any debug grant.
  - Clears on a fetch grant made while `d_req` is low.
- **Single outstanding access**: requests arriving outside IDLE are not acked. They must stay high and are served later.
- **Owner isolation**: the non-owner's rdata and rvalid never change during another port's access.
- **Request withdrawal**: a request dropped before its ack is simply never served; no state is affected.

## Timing

- **Reset values**: all outputs 0, including `f_ack`, `d_ack`, both rvalids, both rdata, `rom_addr`, `rom_clken`, `busy` and `owner`. State is IDLE and `streak` is 0.
- **Latency**:
  - Ack in cycle 0.
  - `rom_clken`/`rom_addr` valid from cycle 1.
  - rvalid in cycle ROM_LATENCY+1.
- **Throughput**: the next ack is possible in cycle ROM_LATENCY+2. Back-to-back accesses therefore take ROM_LATENCY+2 cycles each.
- **`busy`**: high from cycle 1 through the RETURN cycle inclusive.
- **`Enable` falling during WAIT/RETURN**: the access completes and rvalid still pulses. No grant is made in the IDLE cycles that follow.
- **`Reset` mid-access**:
  - The access is aborted immediately and no rvalid is issued.
  - rdata clears to 0.
  - After reset, the requester must re-request.
- **Simultaneous rising requests in IDLE**: resolved in the same cycle; exactly one ack is asserted.

## Structure

- Shared package `rom_arb_pkg` contains:
  - the state enum (IDLE, WAIT, RETURN);
  - owner encodings OWN_FETCH = 0 and OWN_DEBUG = 1;
  - the default ROM_LATENCY.
- One natural sub-module, `rr_starve_guard`, holds the streak counter and the priority decision. Inputs are the two requests, the grant event and the winner; output is the debug-wins selector.
- The datapath (address register, latency counter, rdata registers) and the FSM stay in the top.

## Test plan

- **Single fetch**: ROM_LATENCY = 1, `f_req` with `f_addr` = 0x10, ROM word 0x10 = 0xDEADBEEF. Required: `f_ack` in cycle 0, `rom_clken` = 1 in cycle 1, `f_rvalid` in cycle 2 with `f_rdata` = 0xDEADBEEF, `busy` high in cycles 1–2.
- **Latency sweep**: ROM_LATENCY = 1, 2 and 3, each with the same fetch. Required: rvalid in cycles 2, 3 and 4 respectively, and data correct each time.
- **Both requesters held continuously**, STARVE_LIMIT = 4. Required grant order: F, F, F, F, D, F, F, F, F, D; `d_rdata` matches `d_addr`; `f_rdata` is unchanged during debug accesses.
- **Reset during WAIT** with ROM_LATENCY = 3. Required: no rvalid, all outputs 0 the cycle after reset asserts, and a fresh request afterwards completes normally.
- **Enable low while `f_req` is high**. Required: no ack and `rom_clken` = 0. Raising `Enable` produces the ack in the same cycle. Dropping `Enable` mid-WAIT still produces rvalid.
- **Request raised during another port's WAIT**. Required: it is not acked until the IDLE cycle after RETURN, then it is acked and served.
